// File: rtl/thread_pc_sequencer.sv
// Round-robin PC sequencer for the multithreaded fetch stage: one PC per thread, one fetch per cycle.
// Optional macro PCSEQ_FETCH_COUNT_EN adds a 32-bit issued-fetch counter output (fetch_count).
module thread_pc_sequencer #(
  parameter int                    NUM_THREADS   = 4,
  parameter int                    TID_WIDTH     = 2,
  parameter int                    PC_WIDTH      = 64,
  parameter logic [PC_WIDTH-1:0]   START_PC      = '0,
  parameter int                    THREAD_STRIDE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic                   stall,
  input  logic                   branch_valid,
  input  logic [TID_WIDTH-1:0]   branch_tid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   fetch_valid,
  output logic [TID_WIDTH-1:0]   fetch_tid,
  output logic [PC_WIDTH-1:0]    fetch_pc
`ifdef PCSEQ_FETCH_COUNT_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [TID_WIDTH-1:0]   cur_tid, next_tid;
  logic [PC_WIDTH-1:0]    pc [NUM_THREADS];
  logic                   advance;
  logic                   issue;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    advance     = 1'b0;
    issue       = 1'b0;
    case (state)
      IDLE: if (run && (thread_enable != '0)) state_nxt = RUN;
      RUN: begin
        fetch_valid = thread_enable[cur_tid];
        advance     = !stall;
        issue       = fetch_valid && !stall;
        if (!run || (thread_enable == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_tid = cur_tid;
  assign fetch_pc  = pc[cur_tid];

  // Descending scan so the nearest enabled thread after cur_tid wins; offset
  // NUM_THREADS aliases to cur_tid itself, making it the last resort.
  always_comb begin
    next_tid = cur_tid;
    for (int off = NUM_THREADS; off >= 1; off--) begin
      if (thread_enable[cur_tid + TID_WIDTH'(off)]) next_tid = cur_tid + TID_WIDTH'(off);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        cur_tid <= '0;
    else if (advance) cur_tid <= next_tid;
  end

  // Branch redirect has priority over the +1 advance of the issuing thread.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (reset)
        pc[t] <= START_PC + PC_WIDTH'(THREAD_STRIDE) * PC_WIDTH'(t);
      else if (branch_valid && (branch_tid == TID_WIDTH'(t)))
        pc[t] <= branch_target;
      else if (issue && (cur_tid == TID_WIDTH'(t)))
        pc[t] <= pc[t] + PC_WIDTH'(1);
    end
  end

`ifdef PCSEQ_FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)      fetch_count <= '0;
    else if (issue) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
